// File: rtl/collatz_seq_runner.sv
// Collatz sequence engine: accepts a start value, iterates until 1, overflow or step limit, then reports steps/peak/flags.
// Optional macro COLLATZ_TRACE_EN adds trace_valid/trace_value outputs showing each new value as it is produced.
module collatz_seq_runner #(
   parameter int W         = 8,
   parameter int IW        = 16,
   parameter int SW        = 8,
   parameter int MAX_STEPS = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_value,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [SW-1:0] steps,
   output logic [IW-1:0] peak,
   output logic          ovf,
   output logic          timeout,
   output logic          zero_err
`ifdef COLLATZ_TRACE_EN
   ,
   output logic          trace_valid,
   output logic [IW-1:0] trace_value
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [IW-1:0] r_value;
   logic [IW-1:0] w_nextValue;
   logic [SW-1:0] r_steps;
   logic [SW-1:0] w_nextSteps;
   logic [IW-1:0] r_peak;
   logic [IW-1:0] w_nextPeak;
   logic          r_ovf;
   logic          w_nextOvf;
   logic          r_timeout;
   logic          w_nextTimeout;
   logic          r_zeroErr;
   logic          w_nextZeroErr;

   logic [IW+1:0] w_triple;
   logic          w_tripleOvf;
   logic [IW-1:0] w_stepValue;
   logic          w_doStep;

   // 3n+1 is formed two bits wider than n so the overflow test cannot itself wrap.
   assign w_triple    = ({2'b00, r_value} << 1) + {2'b00, r_value} + (IW+2)'(1);
   assign w_tripleOvf = |w_triple[IW+1:IW];
   assign w_stepValue = r_value[0] ? w_triple[IW-1:0] : (r_value >> 1);

   always_comb begin
      w_nextState   = r_state;
      w_nextValue   = r_value;
      w_nextSteps   = r_steps;
      w_nextPeak    = r_peak;
      w_nextOvf     = r_ovf;
      w_nextTimeout = r_timeout;
      w_nextZeroErr = r_zeroErr;
      w_doStep      = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_nextOvf     = 1'b0;
               w_nextTimeout = 1'b0;
               w_nextSteps   = '0;
               w_nextValue   = IW'(in_value);
               if (in_value == '0) begin
                  w_nextZeroErr = 1'b1;
                  w_nextPeak    = '0;
                  w_nextState   = DONE;
               end else begin
                  w_nextZeroErr = 1'b0;
                  w_nextPeak    = IW'(in_value);
                  w_nextState   = RUN;
               end
            end
         end
         RUN: begin
            if (r_value == IW'(1)) begin
               w_nextState = DONE;
            end else if (r_steps == SW'(MAX_STEPS)) begin
               w_nextTimeout = 1'b1;
               w_nextState   = DONE;
            end else if (r_value[0] && w_tripleOvf) begin
               w_nextOvf   = 1'b1;
               w_nextState = DONE;
            end else begin
               w_doStep    = 1'b1;
               w_nextValue = w_stepValue;
               w_nextSteps = r_steps + SW'(1);
               w_nextPeak  = (w_stepValue > r_peak) ? w_stepValue : r_peak;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_value   <= '0;
         r_steps   <= '0;
         r_peak    <= '0;
         r_ovf     <= 1'b0;
         r_timeout <= 1'b0;
         r_zeroErr <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_value   <= w_nextValue;
         r_steps   <= w_nextSteps;
         r_peak    <= w_nextPeak;
         r_ovf     <= w_nextOvf;
         r_timeout <= w_nextTimeout;
         r_zeroErr <= w_nextZeroErr;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign steps     = r_steps;
   assign peak      = r_peak;
   assign ovf       = r_ovf;
   assign timeout   = r_timeout;
   assign zero_err  = r_zeroErr;

`ifdef COLLATZ_TRACE_EN
   assign trace_valid = w_doStep;
   assign trace_value = w_doStep ? w_stepValue : '0;
`endif

endmodule

// File: tb/tb_collatz_seq_runner.sv
// Directed bench for collatz_seq_runner: three instances (defaults, IW=8, MAX_STEPS=5) share one input stream.
module tb_collatz_seq_runner;

   logic       clk;
   logic       rst;
   logic       inValid;
   logic [7:0] inValue;
   logic       outReady;

   logic        mInReady, mOutValid, mOvf, mTimeout, mZeroErr;
   logic [7:0]  mSteps;
   logic [15:0] mPeak;
   logic        nInReady, nOutValid, nOvf, nTimeout, nZeroErr;
   logic [7:0]  nSteps;
   logic [7:0]  nPeak;
   logic        lInReady, lOutValid, lOvf, lTimeout, lZeroErr;
   logic [7:0]  lSteps;
   logic [15:0] lPeak;

   int testCount;
   int failCount;
   int mLatency;
   int holdBad;

   collatz_seq_runner dutMain (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(mInReady), .in_value(inValue),
      .out_valid(mOutValid), .out_ready(outReady), .steps(mSteps), .peak(mPeak),
      .ovf(mOvf), .timeout(mTimeout), .zero_err(mZeroErr)
   );

   collatz_seq_runner #(.IW(8)) dutNarrow (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(nInReady), .in_value(inValue),
      .out_valid(nOutValid), .out_ready(outReady), .steps(nSteps), .peak(nPeak),
      .ovf(nOvf), .timeout(nTimeout), .zero_err(nZeroErr)
   );

   collatz_seq_runner #(.MAX_STEPS(5)) dutLimit (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(lInReady), .in_value(inValue),
      .out_valid(lOutValid), .out_ready(outReady), .steps(lSteps), .peak(lPeak),
      .ovf(lOvf), .timeout(lTimeout), .zero_err(lZeroErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Offer one start value, then wait until all three instances present a result.
   task automatic applyStimulus(input logic [7:0] value);
      int cycles;
      inValue  = value;
      inValid  = 1'b1;
      @(posedge clk);
      #1;
      inValid  = 1'b0;
      cycles   = 0;
      mLatency = mOutValid ? 0 : -1;
      while (!(mOutValid && nOutValid && lOutValid) && cycles < 500) begin
         @(posedge clk);
         #1;
         cycles++;
         if (mOutValid && mLatency < 0) mLatency = cycles;
      end
      if (cycles >= 500) checkOutput("waitResult", 32'd0, 32'd1);
   endtask

   task automatic releaseResult();
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      checkOutput("relInReady", 32'(mInReady), 32'd1);
      checkOutput("relOutValid", 32'(mOutValid), 32'd0);
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      holdBad   = 0;
      rst       = 1'b1;
      inValid   = 1'b0;
      inValue   = 8'd0;
      outReady  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstInReady", 32'(mInReady), 32'd1);
      checkOutput("rstOutValid", 32'(mOutValid), 32'd0);
      checkOutput("rstSteps", 32'(mSteps), 32'd0);
      checkOutput("rstPeak", 32'(mPeak), 32'd0);
      checkOutput("rstFlags", 32'({mOvf, mTimeout, mZeroErr}), 32'd0);
      rst = 1'b0;

      // Start 6: 3,10,5,16,8,4,2,1; the step-limited instance stops after 5 steps.
      applyStimulus(8'd6);
      checkOutput("s6Latency", 32'(mLatency), 32'd9);
      checkOutput("s6Steps", 32'(mSteps), 32'd8);
      checkOutput("s6Peak", 32'(mPeak), 32'd16);
      checkOutput("s6Flags", 32'({mOvf, mTimeout, mZeroErr}), 32'd0);
      checkOutput("s6NarrowSteps", 32'(nSteps), 32'd8);
      checkOutput("s6NarrowFlags", 32'({nOvf, nTimeout, nZeroErr}), 32'd0);
      checkOutput("s6LimitSteps", 32'(lSteps), 32'd5);
      checkOutput("s6LimitPeak", 32'(lPeak), 32'd16);
      checkOutput("s6LimitFlags", 32'({lOvf, lTimeout, lZeroErr}), 32'b010);
      releaseResult();

      // Start 27: long run, overflows the 8-bit instance at n=107.
      applyStimulus(8'd27);
      checkOutput("s27Steps", 32'(mSteps), 32'd111);
      checkOutput("s27Peak", 32'(mPeak), 32'd9232);
      checkOutput("s27Flags", 32'({mOvf, mTimeout, mZeroErr}), 32'd0);
      checkOutput("s27NarrowSteps", 32'(nSteps), 32'd11);
      checkOutput("s27NarrowPeak", 32'(nPeak), 32'd214);
      checkOutput("s27NarrowFlags", 32'({nOvf, nTimeout, nZeroErr}), 32'b100);
      checkOutput("s27LimitSteps", 32'(lSteps), 32'd5);
      checkOutput("s27LimitPeak", 32'(lPeak), 32'd124);
      checkOutput("s27LimitFlags", 32'({lOvf, lTimeout, lZeroErr}), 32'b010);

      // Backpressure: result must hold for 20 cycles while new starts are offered.
      inValid = 1'b1;
      inValue = 8'd5;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (!mOutValid || mInReady || mSteps != 8'd111 || mPeak != 16'd9232 ||
             !nOutValid || nSteps != 8'd11 || !nOvf) holdBad++;
      end
      inValid = 1'b0;
      checkOutput("holdStable", 32'(holdBad), 32'd0);
      releaseResult();

      applyStimulus(8'd1);
      checkOutput("s1Latency", 32'(mLatency), 32'd1);
      checkOutput("s1Steps", 32'(mSteps), 32'd0);
      checkOutput("s1Peak", 32'(mPeak), 32'd1);
      checkOutput("s1Flags", 32'({mOvf, mTimeout, mZeroErr}), 32'd0);
      releaseResult();

      applyStimulus(8'd0);
      checkOutput("s0Steps", 32'(mSteps), 32'd0);
      checkOutput("s0Peak", 32'(mPeak), 32'd0);
      checkOutput("s0Flags", 32'({mOvf, mTimeout, mZeroErr}), 32'b001);
      checkOutput("s0LimitFlags", 32'({lOvf, lTimeout, lZeroErr}), 32'b001);
      releaseResult();

      // Reset in the middle of a long run.
      inValue = 8'd27;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("midRunBusy", 32'(mInReady), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midRstInReady", 32'(mInReady), 32'd1);
      checkOutput("midRstOutValid", 32'(mOutValid), 32'd0);
      checkOutput("midRstSteps", 32'(mSteps), 32'd0);
      checkOutput("midRstPeak", 32'(mPeak), 32'd0);

      // Fresh run after reset to confirm the block restarts cleanly.
      applyStimulus(8'd6);
      checkOutput("postRstSteps", 32'(mSteps), 32'd8);
      checkOutput("postRstPeak", 32'(mPeak), 32'd16);
      releaseResult();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
